// File: rtl/text_pixel_pipe_if.sv
// Pixel-side bundle between font fetch and palette lookup.
// Master drives the cell/pixel inputs; slave returns the colour.
interface text_pixel_pipe_if #(
   parameter int FONT_W = 8,
   parameter int IDX_W  = 4
);
   localparam int XW = $clog2(FONT_W);

   logic                 frame_start;
   logic                 in_valid;
   logic [FONT_W-1:0]    font_line_data;
   logic [XW-1:0]        char_pix_x;
   logic [3:0]           char_pix_y;
   logic [2*IDX_W-1:0]   bg_fg_index;
   logic                 blink_attr;
   logic                 is_cursor;
   logic                 out_valid;
   logic [IDX_W-1:0]     color_index;

   modport master (
      output frame_start, in_valid, font_line_data,
      output char_pix_x, char_pix_y, bg_fg_index,
      output blink_attr, is_cursor,
      input  out_valid, color_index
   );

   modport slave (
      input  frame_start, in_valid, font_line_data,
      input  char_pix_x, char_pix_y, bg_fg_index,
      input  blink_attr, is_cursor,
      output out_valid, color_index
   );
endinterface

// File: rtl/text_pixel_pipe.sv
// Two-stage text-mode pixel colour pipe: font bit select,
// then blink/cursor shaping and fg/bg palette index choice.
module text_pixel_pipe #(
   parameter int FONT_W        = 8,
   parameter int IDX_W         = 4,
   parameter int MSB_FIRST     = 0,
   parameter int BLINK_FRAMES  = 32,
   parameter int CUR_FIRST_ROW = 14
) (
   input  logic               clk,
   input  logic               rst,
   text_pixel_pipe_if.slave   pix
);
   localparam int XW = $clog2(FONT_W);
   localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_FRAMES - 1);
   localparam logic [4:0] CUR_ROW = 5'(CUR_FIRST_ROW);

   logic [CW-1:0]    frame_cnt_q, frame_cnt_d;
   logic             phase_q, phase_d;

   logic [XW-1:0]    bit_sel;
   logic             bit_d, cur_hit_d;

   logic             valid1_q;
   logic             bit1_q;
   logic             blink1_q;
   logic             cur1_q;
   logic [IDX_W-1:0] fg1_q, bg1_q;

   logic             on_d;
   logic [IDX_W-1:0] color_d;
   logic             out_valid_q;
   logic [IDX_W-1:0] color_q;

   // Frame counter: wrap at BLINK_FRAMES-1 and flip the blink phase.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (pix.frame_start) begin
         if (frame_cnt_q == CNT_MAX) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   // Blink state; phase 1 means blinking cells are visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
      end
   end

   // Font bit pick; FONT_W-1-x equals ~x because FONT_W is a power of 2.
   always_comb begin
      bit_sel   = (MSB_FIRST != 0) ? ~pix.char_pix_x : pix.char_pix_x;
      bit_d     = pix.font_line_data[bit_sel];
      cur_hit_d = pix.is_cursor & ({1'b0, pix.char_pix_y} >= CUR_ROW);
   end

   // Stage 1 register: selected bit plus the cell attributes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid1_q <= 1'b0;
         bit1_q   <= 1'b0;
         blink1_q <= 1'b0;
         cur1_q   <= 1'b0;
         fg1_q    <= '0;
         bg1_q    <= '0;
      end else begin
         valid1_q <= pix.in_valid;
         bit1_q   <= bit_d;
         blink1_q <= pix.blink_attr;
         cur1_q   <= cur_hit_d;
         fg1_q    <= pix.bg_fg_index[IDX_W-1:0];
         bg1_q    <= pix.bg_fg_index[2*IDX_W-1:IDX_W];
      end
   end

   // Blink hides the glyph in phase 0; cursor inverts it in phase 1.
   always_comb begin
      on_d = bit1_q;
      if (blink1_q && !phase_q) begin
         on_d = 1'b0;
      end
      if (cur1_q && phase_q) begin
         on_d = ~on_d;
      end
      color_d = on_d ? fg1_q : bg1_q;
   end

   // Stage 2 register: colour only updates on valid pixels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         color_q     <= '0;
      end else begin
         out_valid_q <= valid1_q;
         if (valid1_q) begin
            color_q <= color_d;
         end
      end
   end

   assign pix.out_valid   = out_valid_q;
   assign pix.color_index = color_q;
endmodule

// File: tb/tb_text_pixel_pipe.sv
// Directed and random checks of text_pixel_pipe, LSB-first
// and MSB-first instances fed the same stimulus.
module tb_text_pixel_pipe;
   localparam int BF = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   text_pixel_pipe_if #(.FONT_W(8), .IDX_W(4)) ifa ();
   text_pixel_pipe_if #(.FONT_W(8), .IDX_W(4)) ifb ();

   assign ifb.frame_start    = ifa.frame_start;
   assign ifb.in_valid       = ifa.in_valid;
   assign ifb.font_line_data = ifa.font_line_data;
   assign ifb.char_pix_x     = ifa.char_pix_x;
   assign ifb.char_pix_y     = ifa.char_pix_y;
   assign ifb.bg_fg_index    = ifa.bg_fg_index;
   assign ifb.blink_attr     = ifa.blink_attr;
   assign ifb.is_cursor      = ifa.is_cursor;

   text_pixel_pipe #(
      .FONT_W(8), .IDX_W(4), .MSB_FIRST(0),
      .BLINK_FRAMES(BF), .CUR_FIRST_ROW(14)
   ) dut_a (
      .clk(clk), .rst(rst), .pix(ifa)
   );

   text_pixel_pipe #(
      .FONT_W(8), .IDX_W(4), .MSB_FIRST(1),
      .BLINK_FRAMES(BF), .CUR_FIRST_ROW(14)
   ) dut_b (
      .clk(clk), .rst(rst), .pix(ifb)
   );

   typedef struct packed {
      logic       v;
      logic [3:0] ca;
      logic [3:0] cb;
   } exp_t;

   exp_t       e1, e2;
   logic [3:0] last_a, last_b;
   int         cnt;
   bit         ph;
   int         checks = 0;
   int         errors = 0;
   string      tag;

   logic [3:0] ta [8];
   logic [3:0] tb [8];

   function automatic logic [3:0] mdl(
      input logic [7:0] font, input logic [2:0] x,
      input logic [3:0] y, input logic [7:0] attr,
      input bit bl, input bit cur, input bit phase, input bit msb);
      logic on;
      on = msb ? font[7 - int'(x)] : font[int'(x)];
      if (bl && !phase) on = 1'b0;
      if (cur && (y >= 4'd14) && phase) on = !on;
      return on ? attr[3:0] : attr[7:4];
   endfunction

   task automatic chk(input string name, input logic [3:0] got,
                      input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s/%s: observed %h expected %h",
                tag, name, got, exp);
      end
   endtask

   task automatic check_out();
      chk("a_valid", {3'b0, ifa.out_valid}, {3'b0, e2.v});
      chk("a_color", ifa.color_index, e2.ca);
      chk("b_valid", {3'b0, ifb.out_valid}, {3'b0, e2.v});
      chk("b_color", ifb.color_index, e2.cb);
   endtask

   task automatic step(
      input bit fs, input bit v, input logic [7:0] font,
      input logic [2:0] x, input logic [3:0] y,
      input logic [7:0] attr, input bit bl, input bit cur,
      input bit use_model, input logic [3:0] ea,
      input logic [3:0] eb);
      logic [3:0] xa, xb;
      @(negedge clk);
      check_out();
      e2 = e1;
      ifa.frame_start    = fs;
      ifa.in_valid       = v;
      ifa.font_line_data = font;
      ifa.char_pix_x     = x;
      ifa.char_pix_y     = y;
      ifa.bg_fg_index    = attr;
      ifa.blink_attr     = bl;
      ifa.is_cursor      = cur;
      if (fs) begin
         if (cnt == BF - 1) begin
            cnt = 0;
            ph  = !ph;
         end else begin
            cnt++;
         end
      end
      xa = ea;
      xb = eb;
      if (use_model) begin
         xa = mdl(font, x, y, attr, bl, cur, ph, 1'b0);
         xb = mdl(font, x, y, attr, bl, cur, ph, 1'b1);
      end
      if (v) begin
         last_a = xa;
         last_b = xb;
      end
      e1 = '{v, last_a, last_b};
   endtask

   task automatic pix(
      input logic [7:0] font, input logic [2:0] x,
      input logic [3:0] y, input logic [7:0] attr,
      input bit bl, input bit cur,
      input logic [3:0] ea, input logic [3:0] eb);
      step(1'b0, 1'b1, font, x, y, attr, bl, cur, 1'b0, ea, eb);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 3'd0, 4'd0, 8'h00,
           1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   task automatic frame();
      step(1'b1, 1'b0, 8'h00, 3'd0, 4'd0, 8'h00,
           1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   initial begin
      ifa.frame_start    = 1'b0;
      ifa.in_valid       = 1'b0;
      ifa.font_line_data = '0;
      ifa.char_pix_x     = '0;
      ifa.char_pix_y     = '0;
      ifa.bg_fg_index    = '0;
      ifa.blink_attr     = 1'b0;
      ifa.is_cursor      = 1'b0;
      e1 = '0;
      e2 = '0;
      last_a = 4'h0;
      last_b = 4'h0;
      cnt = 0;
      ph  = 1'b1;
      ta = '{4'h3, 4'hA, 4'h3, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
      tb = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h3, 4'hA, 4'h3};

      tag = "reset";
      repeat (2) @(negedge clk);
      check_out();
      rst = 1'b0;

      tag = "basic";
      for (int i = 0; i < 8; i++)
         pix(8'h05, 3'(i), 4'd0, 8'hA3, 1'b0, 1'b0, ta[i], tb[i]);
      idle();
      idle();

      tag = "fg_eq_bg";
      pix(8'h05, 3'd0, 4'd0, 8'h55, 1'b0, 1'b0, 4'h5, 4'h5);
      pix(8'h05, 3'd1, 4'd0, 8'h55, 1'b0, 1'b0, 4'h5, 4'h5);
      idle();

      tag = "blink";
      frame();
      pix(8'hFF, 3'd0, 4'd0, 8'hA3, 1'b1, 1'b0, 4'h3, 4'h3);
      frame();
      pix(8'hFF, 3'd0, 4'd0, 8'hA3, 1'b1, 1'b0, 4'hA, 4'hA);
      frame();
      pix(8'hFF, 3'd0, 4'd0, 8'hA3, 1'b1, 1'b0, 4'hA, 4'hA);
      pix(8'hFF, 3'd0, 4'd0, 8'hA3, 1'b0, 1'b0, 4'h3, 4'h3);
      frame();
      pix(8'hFF, 3'd0, 4'd0, 8'hA3, 1'b1, 1'b0, 4'h3, 4'h3);
      idle();

      tag = "cursor";
      pix(8'h05, 3'd0, 4'd13, 8'hA3, 1'b0, 1'b1, 4'h3, 4'hA);
      pix(8'h05, 3'd0, 4'd14, 8'hA3, 1'b0, 1'b1, 4'hA, 4'h3);
      pix(8'h05, 3'd0, 4'd15, 8'hA3, 1'b0, 1'b1, 4'hA, 4'h3);
      pix(8'h05, 3'd0, 4'd15, 8'hA3, 1'b0, 1'b0, 4'h3, 4'hA);
      frame();
      frame();
      pix(8'h05, 3'd0, 4'd14, 8'hA3, 1'b0, 1'b1, 4'h3, 4'hA);
      idle();

      tag = "cur_blink";
      pix(8'h05, 3'd0, 4'd15, 8'hA3, 1'b1, 1'b1, 4'hA, 4'hA);
      pix(8'h05, 3'd1, 4'd15, 8'hA3, 1'b1, 1'b1, 4'hA, 4'hA);
      frame();
      frame();
      pix(8'h05, 3'd0, 4'd15, 8'hA3, 1'b1, 1'b1, 4'hA, 4'h3);
      pix(8'h05, 3'd1, 4'd15, 8'hA3, 1'b1, 1'b1, 4'h3, 4'h3);
      pix(8'h05, 3'd2, 4'd15, 8'hA3, 1'b1, 1'b1, 4'hA, 4'h3);
      idle();
      idle();

      tag = "stream";
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 1)),
              8'($urandom), 3'($urandom), 4'($urandom),
              8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b1, 4'h0, 4'h0);
      end
      idle();
      idle();

      tag = "to_phase0";
      for (int i = 0; i < 4 && ph; i++) frame();
      pix(8'hFF, 3'd0, 4'd0, 8'hA3, 1'b1, 1'b0, 4'hA, 4'hA);
      idle();
      pix(8'h05, 3'd0, 4'd0, 8'hA3, 1'b0, 1'b0, 4'h3, 4'hA);

      tag = "rst_mid";
      @(negedge clk);
      #2 rst = 1'b1;
      ifa.in_valid    = 1'b0;
      ifa.frame_start = 1'b0;
      e2 = '0;
      #1 check_out();
      e1 = '0;
      last_a = 4'h0;
      last_b = 4'h0;
      cnt = 0;
      ph  = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      tag = "post_rst";
      pix(8'hFF, 3'd0, 4'd0, 8'hA3, 1'b1, 1'b0, 4'h3, 4'h3);
      idle();
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
